mem_io_bridge: RTL
==================

# mem_io_bridge

Parametrised memory/IO bridge between the CPU datapath (ALU address, register-file read/write ports) and the data memory plus NUM_CH memory-mapped IO peripherals (buttons, LEDs, switches, tube, …). Memory accesses pass through combinationally. IO accesses are sequenced by a small FSM with registered chip selects, programmable wait states, a CPU stall handshake, registered sign/zero-extended read capture, and a sticky bus-error flag for unmapped IO addresses.

## Interface
Parameters:
- DATA_W, 32, CPU data/address width
- IO_W, 16, width of each IO channel data bus
- NUM_CH, 4, number of IO channels (1..8)
- IO_BASE, 32'hFFFFFC00, IO window base; addr_in[31:8] must equal IO_BASE[31:8]
- CH0_SLOT, 5, addr_in[7:4] value of channel 0; channel k decodes at slot CH0_SLOT+k
- WAIT_CYC, 1, cycles chip select is held per IO access (1..15)

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mRead, mWrite, ioRead, ioWrite  in  1 each  access requests from Controller, held by CPU while stall=1
- isUnsigned  in  1  1 = zero-extend IO read data, 0 = sign-extend
- addr_in  in  DATA_W  ALU result address
- r_rdata  in  DATA_W  register-file read data (store source)
- m_rdata  in  DATA_W  data-memory read data
- io_rdata  in  NUM_CH*IO_W  channel k read data at bits [k*IO_W +: IO_W]
- addr_out  out  DATA_W  address to data memory (= addr_in)
- mem_we  out  1  memory write enable
- write_data  out  DATA_W  store data to memory
- io_wdata  out  IO_W  registered IO write data
- io_rd_cs, io_wr_cs  out  NUM_CH each  registered one-hot read/write chip selects
- r_wdata  out  DATA_W  data to register file
- stall  out  1  CPU must hold current instruction
- bus_err  out  1  sticky: unmapped IO access occurred
- err_addr  out  DATA_W  address of first unmapped IO access

## Operation
- Decode: io_req = ioRead|ioWrite. hit = addr_in[31:8]==IO_BASE[31:8] and CH0_SLOT <= addr_in[7:4] < CH0_SLOT+NUM_CH; ch = addr_in[7:4]-CH0_SLOT.
- Memory path (combinational): addr_out=addr_in; mem_we = mWrite & ~io_req; write_data = mWrite ? r_rdata : 0 (no latch). If io_req and mRead/mWrite both asserted, IO wins.
- r_wdata: mRead & ~io_req -> m_rdata; state DONE -> rd_q; otherwise 0.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: io_req & hit -> latch ch_q, dir_q (read=ioRead), io_wdata <= r_rdata[IO_W-1:0], load cnt=WAIT_CYC, go ACCESS. io_req & ~hit -> no stall, bus_err<=1; err_addr<=addr_in only if bus_err was 0; stay IDLE.
  - ACCESS: io_rd_cs[ch_q] (read) or io_wr_cs[ch_q] (write) high; cnt decrements each cycle; when cnt==1: for reads rd_q <= extend(io_rdata[ch_q]), go DONE.
  - DONE: chip selects low, stall low, r_wdata=rd_q; unconditionally -> IDLE (request still present this cycle is not re-accepted).
- stall = (IDLE & io_req & hit) | ACCESS.
- Extension: isUnsigned ? {0, data} : {{DATA_W-IO_W}{data[IO_W-1]}, data}; isUnsigned sampled at capture.

## Timing
- Reset (async, immediate): state IDLE, io_rd_cs=io_wr_cs=0, io_wdata=0, rd_q=0, cnt=0, bus_err=0, err_addr=0; stall=0 while rst_n low. Reset mid-ACCESS drops chip selects immediately.
- IO access, request first seen in cycle 0: stall high cycles 0..WAIT_CYC; chip select high cycles 1..WAIT_CYC; read data sampled at the rising edge ending cycle WAIT_CYC; cycle WAIT_CYC+1 = DONE, stall low, r_wdata valid, register file writes.
- Total IO latency WAIT_CYC+2 cycles; memory accesses add zero cycles.
- Back-to-back IO instructions: next request accepted in the IDLE cycle after DONE.
- io_wdata and ch_q stable throughout ACCESS regardless of r_rdata/addr_in changes.
- bus_err sticky until reset; later errors do not overwrite err_addr.

## Test plan
- Reset mid-access: rst_n low during ACCESS -> all cs=0, stall=0 immediately; state IDLE after release.
- IO read, WAIT_CYC=1, addr 0xFFFFFC70 (ch2), io_rdata ch2=16'h8001, isUnsigned=0 -> stall high 2 cycles, io_rd_cs=4'b0100 for 1 cycle, DONE r_wdata=32'hFFFF8001; repeat with isUnsigned=1 -> 32'h00008001.
- IO write, WAIT_CYC=3, addr 0xFFFFFC60 (ch1), r_rdata=32'h1234ABCD, r_rdata changed during ACCESS -> io_wr_cs=4'b0010 for 3 cycles, io_wdata=16'hABCD throughout, stall high 4 cycles.
- Memory read/write: mRead, m_rdata=32'hDEADBEEF -> r_wdata same cycle, stall=0; mWrite -> mem_we=1, write_data=r_rdata; no writes -> write_data=0.
- Unmapped IO: ioRead at 0xFFFFFC20 then 0xFFFFFCF0 -> no stall, r_wdata=0, bus_err=1, err_addr=0xFFFFFC20 retained.
- Simultaneous ioWrite+mWrite to ch0 (0xFFFFFC50) -> mem_we=0, IO write sequenced; back-to-back IO read accepted the cycle after DONE.

Source files
------------

// File: rtl/mem_io_bridge.sv
// Memory/IO bridge: memory accesses pass straight through, IO accesses are sequenced by a
// small FSM with registered chip selects, wait states, CPU stall and sticky bus-error capture.
module mem_io_bridge #(
    parameter int                 DATA_W   = 32,
    parameter int                 IO_W     = 16,
    parameter int                 NUM_CH   = 4,
    parameter logic [DATA_W-1:0]  IO_BASE  = 32'hFFFFFC00,
    parameter int                 CH0_SLOT = 5,
    parameter int                 WAIT_CYC = 1
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   mRead,
    input  logic                   mWrite,
    input  logic                   ioRead,
    input  logic                   ioWrite,
    input  logic                   isUnsigned,
    input  logic [DATA_W-1:0]      addr_in,
    input  logic [DATA_W-1:0]      r_rdata,
    input  logic [DATA_W-1:0]      m_rdata,
    input  logic [NUM_CH*IO_W-1:0] io_rdata,
    output logic [DATA_W-1:0]      addr_out,
    output logic                   mem_we,
    output logic [DATA_W-1:0]      write_data,
    output logic [IO_W-1:0]        io_wdata,
    output logic [NUM_CH-1:0]      io_rd_cs,
    output logic [NUM_CH-1:0]      io_wr_cs,
    output logic [DATA_W-1:0]      r_wdata,
    output logic                   stall,
    output logic                   bus_err,
    output logic [DATA_W-1:0]      err_addr
);

    localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [4:0] SLOT_LO = 5'(CH0_SLOT);
    localparam logic [4:0] SLOT_HI = 5'(CH0_SLOT + NUM_CH);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t              r_state, w_next_state;
    logic [CH_W-1:0]     r_ch;
    logic                r_dir;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_rd_q;

    logic                w_io_req, w_hit, w_accept, w_unmapped, w_capture;
    logic [4:0]          w_slot;
    logic [CH_W-1:0]     w_ch, w_ch_nxt;
    logic                w_dir_nxt;
    logic [IO_W-1:0]     w_ch_data;
    logic [DATA_W-1:0]   w_ext_data;
    logic [NUM_CH-1:0]   w_cs_onehot;

    // Address decode: upper bits select the IO window, addr[7:4] selects the channel slot.
    assign w_io_req = ioRead | ioWrite;
    assign w_slot   = {1'b0, addr_in[7:4]};
    assign w_hit    = (addr_in[DATA_W-1:8] == IO_BASE[DATA_W-1:8]) &&
                      (w_slot >= SLOT_LO) && (w_slot < SLOT_HI);
    assign w_ch     = CH_W'(w_slot - SLOT_LO);

    assign addr_out   = addr_in;
    assign mem_we     = mWrite & ~w_io_req;
    assign write_data = mWrite ? r_rdata : '0;

    assign w_ch_data  = io_rdata[r_ch*IO_W +: IO_W];
    assign w_ext_data = isUnsigned ? {{(DATA_W-IO_W){1'b0}}, w_ch_data}
                                   : {{(DATA_W-IO_W){w_ch_data[IO_W-1]}}, w_ch_data};

    // Stall is forced low while reset is asserted, even if a request is on the inputs.
    assign stall   = rst_n & (((r_state == S_IDLE) & w_io_req & w_hit) | (r_state == S_ACCESS));
    assign r_wdata = (mRead & ~w_io_req)  ? m_rdata :
                     (r_state == S_DONE)  ? r_rd_q  : '0;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_unmapped   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_io_req && w_hit) begin
                    w_accept     = 1'b1;
                    w_next_state = S_ACCESS;
                end else if (w_io_req) begin
                    w_unmapped = 1'b1;
                end
            end
            S_ACCESS: begin
                if (r_cnt == 4'd1) begin
                    w_capture    = r_dir;
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_ch_nxt    = w_accept ? w_ch : r_ch;
    assign w_dir_nxt   = w_accept ? ioRead : r_dir;
    assign w_cs_onehot = NUM_CH'(1) << w_ch_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_dir    <= 1'b0;
            r_cnt    <= '0;
            r_rd_q   <= '0;
            io_wdata <= '0;
            io_rd_cs <= '0;
            io_wr_cs <= '0;
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            r_state  <= w_next_state;
            r_ch     <= w_ch_nxt;
            r_dir    <= w_dir_nxt;
            io_rd_cs <= (w_next_state == S_ACCESS &&  w_dir_nxt) ? w_cs_onehot : '0;
            io_wr_cs <= (w_next_state == S_ACCESS && !w_dir_nxt) ? w_cs_onehot : '0;
            if (w_accept) begin
                io_wdata <= r_rdata[IO_W-1:0];
                r_cnt    <= CNT_INIT;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture)
                r_rd_q <= w_ext_data;
            if (w_unmapped) begin
                bus_err <= 1'b1;
                if (!bus_err)
                    err_addr <= addr_in;
            end
        end
    end

endmodule
